mem_lsu: RTL and testbench

//  Load/store initiator that drives the word-addressed memory port (mem_read/mem_write/addr/write_data/read_data).

---
 rtl/mem_lsu.sv | 155 +++++++++++++++
 tb/tb_mem_lsu.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// Load/store unit between the core datapath and a word-addressed memory port.
// One request in flight; sub-word stores are done as read-modify-write.
module mem_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RESP} state_t;

  state_t      state, state_nxt;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic uns);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] ext_s;
    b     = word[8*off +: 8];
    h     = off[1] ? word[31:16] : word[15:0];
    b_s   = b;
    h_s   = h;
    ext_s = '0;
    case (size)
      2'b00: begin
        ext_s = b_s;
        return uns ? {24'd0, b} : ext_s;
      end
      2'b01: begin
        ext_s = h_s;
        return uns ? {16'd0, h} : ext_s;
      end
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic [31:0] wd);
    logic [31:0] r;
    r = word;
    case (size)
      2'b00:   r[8*off +: 8] = wd[7:0];
      2'b01:   if (off[1]) r[31:16] = wd[15:0]; else r[15:0] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  // state register: async reset drops the strobes immediately since they decode from state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (misaligned(req_size, req_addr[1:0]))  state_nxt = RESP;
          else if (req_we && req_size == 2'b10)      state_nxt = WR;
          else                                       state_nxt = RD;
        end
      end
      RD:      state_nxt = RD_WAIT;
      RD_WAIT: state_nxt = we_q ? WR : RESP;
      WR:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign mem_read   = (state == RD);
  assign mem_write  = (state == WR);
  assign resp_valid = (state == RESP);

  // request capture, load result and RMW merge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= 2'b00;
      off_q      <= 2'b00;
      wdata_q    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            uns_q    <= req_unsigned;
            size_q   <= req_size;
            off_q    <= req_addr[1:0];
            wdata_q  <= req_wdata;
            mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
            if (req_we) mem_wdata <= req_wdata;
            if (misaligned(req_size, req_addr[1:0])) begin
              resp_rdata <= '0;
              resp_err   <= 1'b1;
            end
          end
        end
        RD_WAIT: begin
          if (we_q) begin
            mem_wdata <= store_merge(mem_rdata, size_q, off_q, wdata_q);
          end else begin
            resp_rdata <= load_extract(mem_rdata, size_q, off_q, uns_q);
            resp_err   <= 1'b0;
          end
        end
        WR: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed and random requests against a word-array reference model,
// with a simple memory attached to the memory port.
module tb_mem_lsu;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_unsigned = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = '0;

  mem_lsu #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:15] = '{default: 32'h0};
  int          n_rd = 0, n_wr = 0, n_resp = 0, n_both = 0;
  logic [31:0] wr_addr = '0;

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr[5:2]] <= mem_wdata;
      wr_addr            <= mem_addr;
      n_wr               <= n_wr + 1;
    end
    if (mem_read) begin
      mem_rdata <= mem[mem_addr[5:2]];
      n_rd      <= n_rd + 1;
    end
    if (mem_read && mem_write) n_both <= n_both + 1;
    if (resp_valid) n_resp <= n_resp + 1;
  end

  int          total = 0, bad = 0;
  logic [31:0] ref_mem [0:15];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic txn(input bit we, input logic [1:0] size, input bit uns, input logic [31:0] addr,
                     input logic [31:0] wd, output logic [31:0] rd, output logic er);
    bit          exp_err;
    logic [31:0] w, mask, exp_rd;
    int          sh, exp_lat, k, rd0, wr0;
    exp_err = (size == 3) || (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0);
    w       = ref_mem[addr[5:2]];
    if (size == 0)      begin mask = 32'hFF;   sh = 8 * int'(addr % 4); end
    else if (size == 1) begin mask = 32'hFFFF; sh = 16 * int'((addr / 2) % 2); end
    else                begin mask = '1;       sh = 0; end
    exp_rd = 0;
    if (!exp_err && !we) begin
      exp_rd = (w >> sh) & mask;
      if (!uns && size == 0 && exp_rd >= 128)   exp_rd = exp_rd | 32'hFFFFFF00;
      if (!uns && size == 1 && exp_rd >= 32768) exp_rd = exp_rd | 32'hFFFF0000;
    end
    if (!exp_err && we) ref_mem[addr[5:2]] = (w & ~(mask << sh)) | ((wd & mask) << sh);
    exp_lat = exp_err ? 1 : (we && size == 2) ? 2 : !we ? 3 : 4;

    @(negedge clk);
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    check("req_ready_idle", req_ready, 1);
    req_valid = 1; req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    rd0 = n_rd; wr0 = n_wr;
    @(posedge clk);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) req_valid = 0;
    end while (!resp_valid && k < 20);
    check("latency", k, exp_lat);
    check("resp_rdata", resp_rdata, exp_rd);
    check("resp_err", resp_err, exp_err);
    check("mem_read_count", n_rd - rd0, (!exp_err && !(we && size == 2)) ? 1 : 0);
    check("mem_write_count", n_wr - wr0, (!exp_err && we) ? 1 : 0);
    if (!exp_err && we) begin
      check("write_addr", wr_addr, {addr[31:2], 2'b00});
      check("mem_word", mem[addr[5:2]], ref_mem[addr[5:2]]);
    end
    rd = resp_rdata;
    er = resp_err;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          k, resp0;
    bit          ready_bad;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;

    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    rst_n = 1;

    txn(1, 2'd2, 0, 32'h4, 32'hDEADBEEF, rd, er);
    txn(0, 2'd2, 0, 32'h4, 32'h0, rd, er);
    check("t1_word_load", rd, 32'hDEADBEEF);

    txn(1, 2'd2, 0, 32'h0, 32'h80FF7F01, rd, er);
    txn(0, 2'd0, 0, 32'h0, 32'h0, rd, er); check("t2_byte0", rd, 32'h00000001);
    txn(0, 2'd0, 0, 32'h1, 32'h0, rd, er); check("t2_byte1", rd, 32'h0000007F);
    txn(0, 2'd0, 0, 32'h2, 32'h0, rd, er); check("t2_byte2", rd, 32'hFFFFFFFF);
    txn(0, 2'd0, 0, 32'h3, 32'h0, rd, er); check("t2_byte3", rd, 32'hFFFFFF80);
    txn(0, 2'd0, 1, 32'h3, 32'h0, rd, er); check("t2_ubyte3", rd, 32'h00000080);

    txn(1, 2'd2, 0, 32'h8, 32'h11223344, rd, er);
    txn(1, 2'd1, 0, 32'hA, 32'h0000AAAA, rd, er);
    check("t3_half_store", mem[2], 32'hAAAA3344);
    txn(1, 2'd0, 0, 32'h9, 32'h00000055, rd, er);
    check("t3_byte_store", mem[2], 32'hAAAA5544);

    txn(0, 2'd2, 0, 32'h6, 32'h0, rd, er); check("t4_word_mis", er, 1);
    txn(1, 2'd1, 0, 32'h3, 32'h1234, rd, er); check("t4_half_mis", er, 1);
    txn(0, 2'd3, 0, 32'h0, 32'h0, rd, er); check("t4_size11", er, 1);

    // held req_valid with three back-to-back word loads
    @(negedge clk);
    resp0 = n_resp; ready_bad = 0; k = 0;
    req_valid = 1; req_we = 0; req_size = 2'd2; req_unsigned = 0;
    for (int i = 0; i < 3; i++) begin
      req_addr = 32'(4 * i);
      while (!req_ready && k < 100) begin @(negedge clk); k++; end
      @(negedge clk); k++;
      while (!resp_valid && k < 100) begin
        if (req_ready) ready_bad = 1;
        @(negedge clk); k++;
      end
      check("t5_stream_data", resp_rdata, ref_mem[i]);
    end
    req_valid = 0;
    @(negedge clk);
    check("t5_ready_low", ready_bad, 0);
    check("t5_pulses", n_resp - resp0, 3);

    for (int n = 0; n < 40; n++) begin
      txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          32'($urandom_range(0, 63)), $urandom, rd, er);
    end

    // reset in the middle of a word-store write cycle
    @(negedge clk);
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    resp0 = n_resp;
    req_valid = 1; req_we = 1; req_size = 2'd2; req_addr = 32'h3C; req_wdata = ~ref_mem[15];
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    check("t6_wr_active", mem_write, 1);
    #1 rst_n = 0;
    #1;
    check("t6_wr_drop", mem_write, 0);
    check("t6_no_resp", resp_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("t6_ready", req_ready, 1);
    check("t6_resp_count", n_resp - resp0, 0);
    check("t6_mem_kept", mem[15], ref_mem[15]);
    check("t6_rdata_cleared", resp_rdata, 0);

    txn(0, 2'd2, 0, 32'h3C, 32'h0, rd, er);
    check("strobe_overlap", n_both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
